store_align_unit: RTL and testbench

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

---
 rtl/store_align_unit_if.sv | 28 ++
 rtl/store_align_unit.sv | 127 ++++++++++++
 tb/tb_store_align_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_align_unit_if.sv
// Store request handshake and memory write bus of the store align unit.
// The slave side is the unit; the master side drives requests and bus responses.
interface store_align_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        flush;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic        done;
  logic        ades;

  modport slave (
    input  in_valid, in_op, in_addr, in_data, flush, bus_addr_ok, bus_data_ok,
    output in_ready, bus_req, bus_addr, bus_wstrb, bus_wdata, done, ades
  );

  modport master (
    output in_valid, in_op, in_addr, in_data, flush, bus_addr_ok, bus_data_ok,
    input  in_ready, bus_req, bus_addr, bus_wstrb, bus_wdata, done, ades
  );
endinterface

// File: rtl/store_align_unit.sv
// MIPS-style store alignment (SB/SH/SW/SWL/SWR) onto a 32-bit byte-strobed
// write bus with a split address/data handshake, flush and address-error reporting.
module store_align_lane #(
  parameter int LANE = 0
) (
  input  logic [2:0]  op,
  input  logic [1:0]  b,
  input  logic [31:0] data,
  output logic        strb,
  output logic [7:0]  lane_byte
);
  localparam logic [1:0] LN = LANE[1:0];

  logic [1:0] src;
  logic       zero;

  // src picks which rt byte lands in this lane; SWL/SWR lanes outside the strobe read 0
  always_comb begin
    strb = 1'b0;
    src  = 2'd0;
    zero = 1'b0;
    case (op)
      3'b000: strb = (b == LN);
      3'b001: begin strb = (b[1] == LN[1]); src = {1'b0, LN[0]}; end
      3'b010: begin strb = 1'b1; src = LN; end
      3'b011: begin strb = (LN <= b); src = LN + 2'd3 - b; zero = ~strb; end
      3'b100: begin strb = (LN >= b); src = LN - b; zero = ~strb; end
      default: zero = 1'b1;
    endcase
    lane_byte = zero ? 8'h00 : data[{src, 3'b000} +: 8];
  end
endmodule

module store_align_unit (
  input  logic clk,
  input  logic reset,
  store_align_unit_if.slave sif
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, EXC} state_t;

  state_t                        state;
  logic [NUM_LANES-1:0]          lane_strb;
  logic [NUM_LANES-1:0][7:0]     lane_byte;
  logic                          bus_req_q, done_q, ades_q, cancelled, exc_ades;
  logic [31:0]                   bus_addr_q, bus_wdata_q;
  logic [NUM_LANES-1:0]          bus_wstrb_q;
  logic                          addr_err, reserved, accept;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    store_align_lane #(.LANE(k)) u_lane (
      .op       (sif.in_op),
      .b        (sif.in_addr[1:0]),
      .data     (sif.in_data),
      .strb     (lane_strb[k]),
      .lane_byte(lane_byte[k])
    );
  end

  assign addr_err = ((sif.in_op == 3'b001) &  sif.in_addr[0]) |
                    ((sif.in_op == 3'b010) & (sif.in_addr[1:0] != 2'b00));
  assign reserved = (sif.in_op > 3'b100);
  assign accept   = sif.in_valid & sif.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      done_q      <= 1'b0;
      ades_q      <= 1'b0;
      cancelled   <= 1'b0;
      exc_ades    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ades_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bus_addr_q  <= {sif.in_addr[31:2], 2'b00};
          bus_wstrb_q <= lane_strb;
          bus_wdata_q <= lane_byte;
          cancelled   <= 1'b0;
          if (addr_err | reserved) begin
            state    <= EXC;
            exc_ades <= addr_err;
          end else begin
            state     <= ADDR;
            bus_req_q <= 1'b1;
          end
        end
        // a flush racing the address handshake still owes the data phase
        ADDR: if (sif.bus_addr_ok) begin
          state     <= DATA;
          bus_req_q <= 1'b0;
          cancelled <= sif.flush;
        end else if (sif.flush) begin
          state     <= IDLE;
          bus_req_q <= 1'b0;
        end
        DATA: if (sif.bus_data_ok) begin
          state     <= IDLE;
          done_q    <= ~(cancelled | sif.flush);
          cancelled <= 1'b0;
        end else if (sif.flush) begin
          cancelled <= 1'b1;
        end
        EXC: begin
          state  <= IDLE;
          done_q <= ~sif.flush;
          ades_q <= exc_ades & ~sif.flush;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.in_ready  = (state == IDLE) & ~sif.flush;
  assign sif.bus_req   = bus_req_q;
  assign sif.bus_addr  = bus_addr_q;
  assign sif.bus_wstrb = bus_wstrb_q;
  assign sif.bus_wdata = bus_wdata_q;
  assign sif.done      = done_q;
  assign sif.ades      = ades_q;
endmodule

// File: tb/tb_store_align_unit.sv
// Directed-vector bench: stimulus pushes expected bus writes / retirements into
// a scoreboard queue that a negedge monitor pops and checks.
module tb_store_align_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  store_align_unit_if sif ();

  store_align_unit dut (.clk(clk), .reset(reset), .sif(sif));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_done;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ades;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    sb.push_back('{is_done: 1'b0, addr: a, wstrb: s, wdata: d, ades: 1'b0});
  endtask

  task automatic push_done(input logic a);
    sb.push_back('{is_done: 1'b1, addr: 32'h0, wstrb: 4'h0, wdata: 32'h0, ades: a});
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    sif.in_valid = 1'b1;
    sif.in_op    = op;
    sif.in_addr  = a;
    sif.in_data  = d;
    step();
    sif.in_valid = 1'b0;
  endtask

  task automatic run_legal(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ed);
    push_bus(ea, es, ed);
    push_done(1'b0);
    issue(op, a, d);
    repeat (3) step();
  endtask

  task automatic run_exc(input logic [2:0] op, input logic [31:0] a, input logic ea);
    push_done(ea);
    issue(op, a, 32'h0);
    repeat (2) step();
  endtask

  // Monitor: every accepted bus request and every done pulse must match the queue head
  always @(negedge clk) begin
    if (!reset) begin
      if (sif.bus_req && sif.bus_addr_ok) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          total++;
          $display("FAIL bus_unexpected: got addr %h wstrb %b, want no bus request", sif.bus_addr, sif.bus_wstrb);
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bus_addr",  sif.bus_addr,  e.addr);
          chk("bus_wstrb", {28'h0, sif.bus_wstrb}, {28'h0, e.wstrb});
          chk("bus_wdata", sif.bus_wdata, e.wdata);
        end
      end
      if (sif.done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          total++;
          $display("FAIL done_unexpected: got done=1 ades=%b, want no done", sif.ades);
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ades", {31'h0, sif.ades}, {31'h0, e.ades});
        end
      end
    end
  end

  initial begin
    sif.in_valid = 1'b0; sif.in_op = 3'b000; sif.in_addr = '0; sif.in_data = '0;
    sif.flush = 1'b0; sif.bus_addr_ok = 1'b1; sif.bus_data_ok = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_bus_req",   sif.bus_req, 0);
    chk("rst_bus_addr",  sif.bus_addr, 0);
    chk("rst_bus_wstrb", sif.bus_wstrb, 0);
    chk("rst_bus_wdata", sif.bus_wdata, 0);
    chk("rst_done",      sif.done, 0);
    chk("rst_ades",      sif.ades, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", sif.in_ready, 1);
    step();

    // SWL with latency checks: accept T, bus_req T+1, done T+3
    push_bus(32'h1000, 4'b0111, 32'h00AABBCC);
    push_done(1'b0);
    issue(3'b011, 32'h1002, 32'hAABBCCDD);
    @(negedge clk); chk("lat_req_t1", sif.bus_req, 1); chk("lat_rdy_t1", sif.in_ready, 0);
    @(negedge clk); chk("lat_req_t2", sif.bus_req, 0); chk("lat_done_t2", sif.done, 0);
    @(negedge clk); chk("lat_done_t3", sif.done, 1);
    step();

    run_legal(3'b100, 32'h1003, 32'hAABBCCDD, 32'h1000, 4'b1000, 32'hDD000000);
    run_legal(3'b000, 32'h2001, 32'h0000005A, 32'h2000, 4'b0010, 32'h5A5A5A5A);
    run_legal(3'b001, 32'h3002, 32'h12345678, 32'h3000, 4'b1100, 32'h56785678);
    run_legal(3'b001, 32'h3000, 32'h12345678, 32'h3000, 4'b0011, 32'h56785678);
    run_legal(3'b010, 32'h4000, 32'hDEADBEEF, 32'h4000, 4'b1111, 32'hDEADBEEF);
    run_legal(3'b011, 32'h4003, 32'hAABBCCDD, 32'h4000, 4'b1111, 32'hAABBCCDD);
    run_legal(3'b011, 32'h4000, 32'hAABBCCDD, 32'h4000, 4'b0001, 32'h000000AA);
    run_legal(3'b100, 32'h4001, 32'hAABBCCDD, 32'h4000, 4'b1110, 32'hBBCCDD00);
    run_legal(3'b000, 32'h4003, 32'h00000011, 32'h4000, 4'b1000, 32'h11111111);

    // misaligned SW: no bus request, done+ades one cycle after EXC
    push_done(1'b1);
    issue(3'b010, 32'h3002, 32'h0);
    @(negedge clk); chk("exc_no_req", sif.bus_req, 0); chk("exc_done_early", sif.done, 0);
    @(negedge clk); chk("exc_done", sif.done, 1);
    step();
    run_exc(3'b001, 32'h3001, 1'b1);
    run_exc(3'b101, 32'h3000, 1'b0);

    // address phase stalled 5 cycles; data_ok held high must be ignored in ADDR
    sif.bus_addr_ok = 1'b0;
    push_bus(32'h5004, 4'b1111, 32'hCAFEF00D);
    push_done(1'b0);
    issue(3'b010, 32'h5004, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req",   sif.bus_req, 1);
      chk("stall_addr",  sif.bus_addr, 32'h5004);
      chk("stall_wstrb", sif.bus_wstrb, 4'b1111);
      chk("stall_wdata", sif.bus_wdata, 32'hCAFEF00D);
      chk("stall_ready", sif.in_ready, 0);
    end
    step();
    sif.bus_addr_ok = 1'b1;
    repeat (3) step();

    // flush together with addr_ok: data phase still waited for, no done
    sif.bus_addr_ok = 1'b0; sif.bus_data_ok = 1'b0;
    push_bus(32'h6000, 4'b0001, 32'h77777777);
    issue(3'b000, 32'h6000, 32'h00000077);
    sif.flush = 1'b1; sif.bus_addr_ok = 1'b1;
    step();
    sif.flush = 1'b0; sif.bus_addr_ok = 1'b0;
    @(negedge clk); chk("fl_wait_data1", sif.in_ready, 0);
    step();
    @(negedge clk); chk("fl_wait_data2", sif.in_ready, 0);
    step();
    sif.bus_data_ok = 1'b1;
    step();
    sif.bus_data_ok = 1'b0;
    @(negedge clk); chk("fl_no_done", sif.done, 0); chk("fl_idle", sif.in_ready, 1);
    step();

    // flush in ADDR without addr_ok: request withdrawn
    issue(3'b000, 32'h6100, 32'h00000001);
    sif.flush = 1'b1;
    step();
    sif.flush = 1'b0;
    @(negedge clk); chk("fla_req_drop", sif.bus_req, 0); chk("fla_idle", sif.in_ready, 1);
    step();
    sif.bus_addr_ok = 1'b1; sif.bus_data_ok = 1'b1;

    // flush in EXC suppresses done/ades
    issue(3'b010, 32'h7001, 32'h0);
    sif.flush = 1'b1;
    step();
    sif.flush = 1'b0;
    @(negedge clk); chk("fle_no_done", sif.done, 0);
    step();

    // flush in IDLE blocks acceptance
    sif.flush = 1'b1;
    issue(3'b000, 32'h8000, 32'h00000042);
    sif.flush = 1'b0;
    @(negedge clk); chk("fli_no_req", sif.bus_req, 0); chk("fli_ready", sif.in_ready, 1);
    step();

    // reset while in DATA: outputs clear at once, later data_ok ignored
    sif.bus_data_ok = 1'b0;
    push_bus(32'h9000, 4'b1100, 32'hBEEFBEEF);
    issue(3'b001, 32'h9002, 32'h0000BEEF);
    step();
    sif.bus_addr_ok = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mrst_bus_req",   sif.bus_req, 0);
    chk("mrst_bus_addr",  sif.bus_addr, 0);
    chk("mrst_bus_wstrb", sif.bus_wstrb, 0);
    chk("mrst_bus_wdata", sif.bus_wdata, 0);
    chk("mrst_done",      sif.done, 0);
    chk("mrst_ades",      sif.ades, 0);
    step();
    reset = 1'b0;
    sif.bus_data_ok = 1'b1;
    @(negedge clk); chk("mrst_ready", sif.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk); chk("mrst_no_done", sif.done, 0);
    end
    step();

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
